// File: rtl/vga_timing_generator.sv
// Two-axis VGA timing with run-time geometry shadow-latched at frame boundaries; syncs/VideoOn registered with position.
// Outputs change on the same edge as xposition/yposition; Enable=0 freezes all state (no other backpressure).
module vga_timing_generator #(
    parameter int XBITS = 10,
    parameter int YBITS = 10,
    parameter int FBITS = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             PixelTick,
    input  logic             Enable,
    input  logic             Restart,
    input  logic [XBITS-1:0] HActive,
    input  logic [XBITS-1:0] HFront,
    input  logic [XBITS-1:0] HSync,
    input  logic [XBITS-1:0] HBack,
    input  logic [YBITS-1:0] VActive,
    input  logic [YBITS-1:0] VFront,
    input  logic [YBITS-1:0] VSync,
    input  logic [YBITS-1:0] VBack,
    input  logic             HPol,
    input  logic             VPol,
    output logic             hsync,
    output logic             vsync,
    output logic [XBITS-1:0] xposition,
    output logic [YBITS-1:0] yposition,
    output logic             VideoOn,
    output logic             LineEnd,
    output logic             FrameEnd,
    output logic [FBITS-1:0] FrameCount,
    output logic             ConfigError
);
    // Two spare bits so the four-segment sum cannot wrap before the legality check.
    localparam int XW = XBITS + 2;
    localparam int YW = YBITS + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    typedef struct packed {
        logic [XBITS-1:0] act;
        logic [XBITS-1:0] fp;
        logic [XBITS-1:0] sy;
        logic [XBITS-1:0] bp;
        logic             pol;
    } h_cfg_t;

    typedef struct packed {
        logic [YBITS-1:0] act;
        logic [YBITS-1:0] fp;
        logic [YBITS-1:0] sy;
        logic [YBITS-1:0] bp;
        logic             pol;
    } v_cfg_t;

    logic [1:0]       state, state_nxt;
    logic [XBITS-1:0] x, x_nxt;
    logic [YBITS-1:0] y, y_nxt;
    logic [FBITS-1:0] fcnt, fcnt_nxt;
    h_cfg_t           hcfg, hcfg_nxt, h_in;
    v_cfg_t           vcfg, vcfg_nxt, v_in;
    logic             in_ok, x_last, y_last, adv;
    logic             hsync_nxt, vsync_nxt, video_nxt;
    logic [XW-1:0]    hs_beg, hs_end;
    logic [YW-1:0]    vs_beg, vs_end;

    function automatic logic [XW-1:0] h_total(input h_cfg_t c);
        return XW'(c.act) + XW'(c.fp) + XW'(c.sy) + XW'(c.bp);
    endfunction

    function automatic logic [YW-1:0] v_total(input v_cfg_t c);
        return YW'(c.act) + YW'(c.fp) + YW'(c.sy) + YW'(c.bp);
    endfunction

    assign h_in = {HActive, HFront, HSync, HBack, HPol};
    assign v_in = {VActive, VFront, VSync, VBack, VPol};

    assign in_ok = (h_total(h_in) <= (XW'(1) << XBITS)) &&
                   (v_total(v_in) <= (YW'(1) << YBITS)) &&
                   (|HActive) && (|VActive) && (|HSync) && (|VSync);

    assign x_last = (XW'(x) == h_total(hcfg) - XW'(1));
    assign y_last = (YW'(y) == v_total(vcfg) - YW'(1));
    assign adv    = Enable && PixelTick && !Restart && (state == S_RUN);

    assign LineEnd     = adv && x_last;
    assign FrameEnd    = LineEnd && y_last;
    assign xposition   = x;
    assign yposition   = y;
    assign FrameCount  = fcnt;
    assign ConfigError = (state == S_ERROR);

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        fcnt_nxt  = fcnt;
        hcfg_nxt  = hcfg;
        vcfg_nxt  = vcfg;
        if (Enable) begin
            if (Restart && state != S_IDLE) begin
                state_nxt = S_LOAD;
                x_nxt     = '0;
                y_nxt     = '0;
            end else begin
                case (state)
                    S_IDLE: state_nxt = S_LOAD;
                    S_LOAD: begin
                        hcfg_nxt  = h_in;
                        vcfg_nxt  = v_in;
                        x_nxt     = '0;
                        y_nxt     = '0;
                        state_nxt = in_ok ? S_RUN : S_ERROR;
                    end
                    S_RUN: if (PixelTick) begin
                        if (x_last) begin
                            x_nxt = '0;
                            if (y_last) begin
                                y_nxt    = '0;
                                fcnt_nxt = fcnt + FBITS'(1);
                                hcfg_nxt = h_in;
                                vcfg_nxt = v_in;
                                if (!in_ok) state_nxt = S_ERROR;
                            end else begin
                                y_nxt = y + YBITS'(1);
                            end
                        end else begin
                            x_nxt = x + XBITS'(1);
                        end
                    end
                    S_ERROR: if (PixelTick) begin
                        hcfg_nxt = h_in;
                        vcfg_nxt = v_in;
                        x_nxt    = '0;
                        y_nxt    = '0;
                        if (in_ok) state_nxt = S_RUN;
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // Decode from next-state values so registered outputs line up with the new position.
    assign hs_beg = XW'(hcfg_nxt.act) + XW'(hcfg_nxt.fp);
    assign hs_end = hs_beg + XW'(hcfg_nxt.sy);
    assign vs_beg = YW'(vcfg_nxt.act) + YW'(vcfg_nxt.fp);
    assign vs_end = vs_beg + YW'(vcfg_nxt.sy);

    always_comb begin
        hsync_nxt = ~hcfg_nxt.pol;
        vsync_nxt = ~vcfg_nxt.pol;
        video_nxt = 1'b0;
        if (state_nxt == S_RUN) begin
            if (XW'(x_nxt) >= hs_beg && XW'(x_nxt) < hs_end) hsync_nxt = hcfg_nxt.pol;
            if (YW'(y_nxt) >= vs_beg && YW'(y_nxt) < vs_end) vsync_nxt = vcfg_nxt.pol;
            video_nxt = (x_nxt < hcfg_nxt.act) && (y_nxt < vcfg_nxt.act);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            x       <= '0;
            y       <= '0;
            fcnt    <= '0;
            hcfg    <= '0;
            vcfg    <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            VideoOn <= 1'b0;
        end else begin
            state   <= state_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            fcnt    <= fcnt_nxt;
            hcfg    <= hcfg_nxt;
            vcfg    <= vcfg_nxt;
            hsync   <= hsync_nxt;
            vsync   <= vsync_nxt;
            VideoOn <= video_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: 14x8 frame geometry plus a 4-bit-x instance for the wrap boundary.
module tb_vga_timing_generator;
    logic       Clock, Reset, PixelTick, Enable, Restart;
    logic [9:0] HActive, HFront, HSync, HBack;
    logic [9:0] VActive, VFront, VSync, VBack;
    logic       HPol, VPol;
    logic       hsync, vsync, VideoOn, LineEnd, FrameEnd, ConfigError;
    logic [9:0] xposition, yposition;
    logic [7:0] FrameCount;

    logic [3:0] h4_act, h4_fp, h4_sy, h4_bp;
    logic       hsync4, vsync4, video4, le4, fe4, cerr4;
    logic [3:0] x4;
    logic [9:0] y4;
    logic [7:0] fc4;

    int checks = 0;
    int errors = 0;

    logic [24:0] obs;
    assign obs = {xposition, yposition, hsync, vsync, VideoOn, LineEnd, FrameEnd};

    vga_timing_generator dut (
        .Clock(Clock), .Reset(Reset), .PixelTick(PixelTick), .Enable(Enable), .Restart(Restart),
        .HActive(HActive), .HFront(HFront), .HSync(HSync), .HBack(HBack),
        .VActive(VActive), .VFront(VFront), .VSync(VSync), .VBack(VBack),
        .HPol(HPol), .VPol(VPol),
        .hsync(hsync), .vsync(vsync), .xposition(xposition), .yposition(yposition),
        .VideoOn(VideoOn), .LineEnd(LineEnd), .FrameEnd(FrameEnd),
        .FrameCount(FrameCount), .ConfigError(ConfigError)
    );

    vga_timing_generator #(.XBITS(4), .YBITS(10), .FBITS(8)) dut4 (
        .Clock(Clock), .Reset(Reset), .PixelTick(PixelTick), .Enable(Enable), .Restart(Restart),
        .HActive(h4_act), .HFront(h4_fp), .HSync(h4_sy), .HBack(h4_bp),
        .VActive(VActive), .VFront(VFront), .VSync(VSync), .VBack(VBack),
        .HPol(HPol), .VPol(VPol),
        .hsync(hsync4), .vsync(vsync4), .xposition(x4), .yposition(y4),
        .VideoOn(video4), .LineEnd(le4), .FrameEnd(fe4),
        .FrameCount(fc4), .ConfigError(cerr4)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Expected {x, y, hsync, vsync, VideoOn, LineEnd, FrameEnd} with HF=2, HS=3, V=4/1/2/1, active-low syncs.
    function automatic logic [24:0] exp_vec(input int ex, input int ey, input int ha, input int ht, input bit adv);
        logic hs, vs, vid, le, fe;
        hs  = !(ex >= ha + 2 && ex < ha + 5);
        vs  = !(ey == 5 || ey == 6);
        vid = (ex < ha) && (ey < 4);
        le  = adv && (ex == ht - 1);
        fe  = le && (ey == 7);
        return {10'(ex), 10'(ey), hs, vs, vid, le, fe};
    endfunction

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b0; Enable = 1'b1; PixelTick = 1'b1; Restart = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({obs, FrameCount, ConfigError} !== {10'd0, 10'd0, 5'b11000, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", {obs, FrameCount, ConfigError}, {10'd0, 10'd0, 5'b11000, 8'd0, 1'b0});
        end
        Reset = 1'b1;
        step();
        checks++;
        if ({xposition, VideoOn, ConfigError} !== {10'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_state: got x=%0d vid=%b cerr=%b expected x=0 vid=0 cerr=0", xposition, VideoOn, ConfigError);
        end
        step();
        checks++;
        if (obs !== exp_vec(0, 0, 8, 14, 1'b1)) begin
            errors++;
            $display("FAIL run_start: got %h expected %h", obs, exp_vec(0, 0, 8, 14, 1'b1));
        end
    endtask

    task automatic test_frame_timing;
        for (int i = 0; i < 112; i++) begin
            checks++;
            if (obs !== exp_vec(i % 14, i / 14, 8, 14, 1'b1) || FrameCount !== 8'd0) begin
                errors++;
                $display("FAIL frame[%0d]: got %h fc=%0d expected %h fc=0", i, obs, FrameCount, exp_vec(i % 14, i / 14, 8, 14, 1'b1));
            end
            step();
        end
        checks++;
        if ({xposition, yposition, FrameCount} !== {10'd0, 10'd0, 8'd1}) begin
            errors++;
            $display("FAIL frame_wrap: got x=%0d y=%0d fc=%0d expected 0 0 1", xposition, yposition, FrameCount);
        end
    endtask

    task automatic test_tick_enable;
        int  ex = 0, ey = 0, p, fe_cyc = -1;
        bit  en, tk, seen = 1'b0;
        for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
            en = !(cyc >= 50 && cyc < 70);
            p  = (cyc < 50) ? cyc : ((cyc < 70) ? 50 : cyc - 20);
            // While frozen the tick is forced high to show it is ignored.
            tk = en ? (p % 4 == 0) : 1'b1;
            Enable = en; PixelTick = tk;
            #1;
            checks++;
            if (obs !== exp_vec(ex, ey, 8, 14, en && tk)) begin
                errors++;
                $display("FAIL tick_en[%0d]: got %h expected %h", cyc, obs, exp_vec(ex, ey, 8, 14, en && tk));
            end
            if (FrameEnd === 1'b1) begin
                seen   = 1'b1;
                fe_cyc = cyc;
            end
            @(posedge Clock);
            #1;
            if (en && tk) begin
                if (ex == 13) begin
                    ex = 0;
                    ey = (ey == 7) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
            end
        end
        // 448 enabled cycles per frame plus 20 frozen ones: FrameEnd lands on cycle 464, next frame ticks at 468.
        checks++;
        if (fe_cyc !== 464) begin
            errors++;
            $display("FAIL tick_frame_len: got FrameEnd at cycle %0d expected 464", fe_cyc);
        end
        checks++;
        if ({xposition, yposition, FrameCount} !== {10'd0, 10'd0, 8'd2}) begin
            errors++;
            $display("FAIL tick_wrap: got x=%0d y=%0d fc=%0d expected 0 0 2", xposition, yposition, FrameCount);
        end
        Enable = 1'b1; PixelTick = 1'b1;
    endtask

    task automatic test_shadow_reload;
        for (int i = 0; i < 112; i++) begin
            if (i == 28) HActive = 10'd6;
            checks++;
            if (obs !== exp_vec(i % 14, i / 14, 8, 14, 1'b1)) begin
                errors++;
                $display("FAIL shadow_old[%0d]: got %h expected %h", i, obs, exp_vec(i % 14, i / 14, 8, 14, 1'b1));
            end
            step();
        end
        for (int i = 0; i < 96; i++) begin
            checks++;
            if (obs !== exp_vec(i % 12, i / 12, 6, 12, 1'b1)) begin
                errors++;
                $display("FAIL shadow_new[%0d]: got %h expected %h", i, obs, exp_vec(i % 12, i / 12, 6, 12, 1'b1));
            end
            step();
        end
        checks++;
        if ({xposition, yposition, FrameCount} !== {10'd0, 10'd0, 8'd4}) begin
            errors++;
            $display("FAIL shadow_wrap: got x=%0d y=%0d fc=%0d expected 0 0 4", xposition, yposition, FrameCount);
        end
    endtask

    task automatic test_config_error;
        HSync = 10'd0;
        repeat (95) step();
        checks++;
        if (obs !== exp_vec(11, 7, 6, 12, 1'b1)) begin
            errors++;
            $display("FAIL cerr_last_pixel: got %h expected %h", obs, exp_vec(11, 7, 6, 12, 1'b1));
        end
        step();
        checks++;
        if ({obs, ConfigError, FrameCount} !== {10'd0, 10'd0, 5'b11000, 1'b1, 8'd5}) begin
            errors++;
            $display("FAIL cerr_enter: got %h expected %h", {obs, ConfigError, FrameCount}, {10'd0, 10'd0, 5'b11000, 1'b1, 8'd5});
        end
        repeat (3) step();
        checks++;
        if ({ConfigError, xposition, yposition} !== {1'b1, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL cerr_hold: got cerr=%b x=%0d y=%0d expected 1 0 0", ConfigError, xposition, yposition);
        end
        HSync = 10'd3; HActive = 10'd8;
        step();
        checks++;
        if ({ConfigError, obs} !== {1'b0, exp_vec(0, 0, 8, 14, 1'b1)}) begin
            errors++;
            $display("FAIL cerr_recover: got cerr=%b %h expected 0 %h", ConfigError, obs, exp_vec(0, 0, 8, 14, 1'b1));
        end
        step();
        checks++;
        if (obs !== exp_vec(1, 0, 8, 14, 1'b1)) begin
            errors++;
            $display("FAIL cerr_resume: got %h expected %h", obs, exp_vec(1, 0, 8, 14, 1'b1));
        end
    endtask

    task automatic test_restart_reset;
        repeat (48) step();
        checks++;
        if (obs !== exp_vec(7, 3, 8, 14, 1'b1)) begin
            errors++;
            $display("FAIL restart_pos: got %h expected %h", obs, exp_vec(7, 3, 8, 14, 1'b1));
        end
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        checks++;
        if ({xposition, yposition, LineEnd, ConfigError} !== {10'd0, 10'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL restart_load: got x=%0d y=%0d le=%b cerr=%b expected 0 0 0 0", xposition, yposition, LineEnd, ConfigError);
        end
        step();
        checks++;
        if (obs !== exp_vec(0, 0, 8, 14, 1'b1)) begin
            errors++;
            $display("FAIL restart_run: got %h expected %h", obs, exp_vec(0, 0, 8, 14, 1'b1));
        end
        step();
        repeat (80) step();
        checks++;
        if ({obs, FrameCount} !== {exp_vec(11, 5, 8, 14, 1'b1), 8'd5}) begin
            errors++;
            $display("FAIL pre_reset: got %h fc=%0d expected %h fc=5", obs, FrameCount, exp_vec(11, 5, 8, 14, 1'b1));
        end
        #3 Reset = 1'b0;
        #1;
        checks++;
        if ({obs, FrameCount, ConfigError} !== {10'd0, 10'd0, 5'b11000, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", {obs, FrameCount, ConfigError}, {10'd0, 10'd0, 5'b11000, 8'd0, 1'b0});
        end
    endtask

    task automatic test_xbits4;
        logic [5:0] exp4;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            exp4 = {4'(i), !(i >= 10 && i <= 12), (i == 15)};
            checks++;
            if ({x4, hsync4, le4} !== exp4) begin
                errors++;
                $display("FAIL x4_line[%0d]: got %h expected %h", i, {x4, hsync4, le4}, exp4);
            end
            step();
        end
        checks++;
        if ({x4, y4, cerr4} !== {4'd0, 10'd1, 1'b0}) begin
            errors++;
            $display("FAIL x4_wrap: got x=%0d y=%0d cerr=%b expected 0 1 0", x4, y4, cerr4);
        end
        h4_bp = 4'd4;
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        step();
        checks++;
        if ({cerr4, x4, ConfigError} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL x4_ht17: got cerr4=%b x4=%0d cerr=%b expected 1 0 0", cerr4, x4, ConfigError);
        end
    endtask

    initial begin
        Reset = 1'b0; Enable = 1'b1; PixelTick = 1'b1; Restart = 1'b0;
        HActive = 10'd8; HFront = 10'd2; HSync = 10'd3; HBack = 10'd1;
        VActive = 10'd4; VFront = 10'd1; VSync = 10'd2; VBack = 10'd1;
        HPol = 1'b0; VPol = 1'b0;
        h4_act = 4'd8; h4_fp = 4'd2; h4_sy = 4'd3; h4_bp = 4'd3;
        test_reset();
        test_frame_timing();
        test_tick_enable();
        test_shadow_reload();
        test_config_error();
        test_restart_reset();
        test_xbits4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
